// File: rtl/weight_pkg.sv
// Shared configuration and state encoding for the weight staging array.
package weight_pkg;

    localparam int unsigned COLS_DEF   = 32;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned BUS_W_DEF  = 32;
    localparam int unsigned DEPTH_DEF  = 32;

    localparam int unsigned PACK  = BUS_W_DEF / DATA_W_DEF;
    localparam int unsigned CNT_W = $clog2(DEPTH_DEF + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH_DEF);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/weight_col_fifo.sv
// One PE-column weight FIFO: multi-lane write, single pop, replay snapshot,
// zero-gated registered output.
module weight_col_fifo
    import weight_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned LANES  = PACK
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [LANES*DATA_W-1:0]     wr_data,
    input  logic                        pop,
    input  logic                        snap,
    input  logic                        restore,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_vld,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        free_ok
);

    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
    localparam int unsigned PTR_BITS = $clog2(DEPTH);

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS-1:0] snap_ptr;
    logic [CNT_BITS-1:0] snap_cnt;

    // A column only takes whole words, never a partial one.
    assign free_ok = (count <= CNT_BITS'(DEPTH - LANES));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(LANES); i++) begin
                mem[wr_ptr + PTR_BITS'(i)] <= wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (restore) begin
            rd_ptr <= snap_ptr;
            count  <= snap_cnt;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_BITS'(LANES);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            count <= count + (wr_en ? CNT_BITS'(LANES) : '0) - (pop ? CNT_BITS'(1) : '0);
        end
    end

    // Read position captured at drain start so a replay can rewind to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_ptr <= '0;
            snap_cnt <= '0;
        end else if (snap) begin
            snap_ptr <= rd_ptr;
            snap_cnt <= count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_vld  <= pop;
            rd_data <= pop ? mem[rd_ptr] : '0;
        end
    end

endmodule

// File: rtl/weight_skew_array.sv
// Per-column weight FIFOs drained with a one-cycle-per-column diagonal skew
// toward the top row of the systolic PE array.
module weight_skew_array
    import weight_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned BUS_W  = BUS_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [BUS_W-1:0]            wr_data,
    input  logic [$clog2(COLS)-1:0]     wr_col,
    input  logic                        wr_bcast,
    input  logic                        flush,
    input  logic                        start,
    input  logic                        replay,
    input  logic [$clog2(DEPTH+1)-1:0]  weight_dim,
    output logic [DATA_W-1:0]           weight_out [COLS],
    output logic [COLS-1:0]             out_vld,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned LANES    = BUS_W / DATA_W;
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
    localparam int unsigned COL_BITS = $clog2(COLS);
    localparam int unsigned T_BITS   = $clog2(DEPTH + COLS + 1);

    state_t              state;
    state_t              state_n;
    logic [T_BITS-1:0]   t;
    logic [T_BITS-1:0]   tn;
    logic [CNT_BITS-1:0] wd_r;
    logic                rep_r;

    logic [COLS-1:0]     col_hit;
    logic [COLS-1:0]     free_ok;
    logic [COLS-1:0]     cnt_ge;
    logic [COLS-1:0]     wr_en;
    logic [COLS-1:0]     pop;
    logic [COLS-1:0]     kick;
    logic [CNT_BITS-1:0] count [COLS];

    logic hs;
    logic is_idle;
    logic clr;
    logic start_ok;
    logic start_bad;
    logic drop;
    logic last;
    logic restore;

    assign is_idle   = (state == IDLE);
    assign hs        = wr_valid && wr_ready;
    assign clr       = flush && is_idle;
    assign start_ok  = is_idle && start && !flush && (weight_dim != '0) && (&cnt_ge);
    assign start_bad = is_idle && start && !flush && !((weight_dim != '0) && (&cnt_ge));
    assign drop      = hs && !flush && !wr_bcast && !(|col_hit);
    assign tn        = t + T_BITS'(1);
    assign last      = (state == DRAIN) && (t == T_BITS'(wd_r) + T_BITS'(COLS - 2));
    assign restore   = last && rep_r;
    assign kick      = COLS'(start_ok);
    assign busy      = (state == DRAIN);

    // Out-of-range non-broadcast columns accept the word so it can be dropped.
    always_comb begin
        wr_ready = 1'b0;
        if (is_idle && !start) begin
            wr_ready = wr_bcast ? (&free_ok) : (!(|col_hit) || (|(col_hit & free_ok)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_ok) state_n = DRAIN;
            DRAIN:   if (last)     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t     <= '0;
            wd_r  <= '0;
            rep_r <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= last;
            err  <= start_bad || drop;
            if (start_ok) begin
                t     <= '0;
                wd_r  <= weight_dim;
                rep_r <= replay;
            end else if (state == DRAIN) begin
                t <= tn;
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [T_BITS-1:0] rel;

        // Unsigned wrap makes rel huge while tn < c, so one compare covers the window.
        assign rel        = tn - T_BITS'(c);
        assign col_hit[c] = (wr_col == COL_BITS'(c));
        assign cnt_ge[c]  = (count[c] >= weight_dim);
        assign wr_en[c]   = hs && !flush && (wr_bcast || col_hit[c]);
        assign pop[c]     = kick[c] || ((state == DRAIN) && (rel < T_BITS'(wd_r)));

        weight_col_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .LANES  (LANES)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .wr_en   (wr_en[c]),
            .wr_data (wr_data),
            .pop     (pop[c]),
            .snap    (start_ok),
            .restore (restore),
            .rd_data (weight_out[c]),
            .rd_vld  (out_vld[c]),
            .count   (count[c]),
            .free_ok (free_ok[c])
        );
    end

endmodule

// File: tb/tb_weight_skew_array.sv
// Scoreboard bench for weight_skew_array: queue-based reference model feeds
// expected per-column streams; a negedge monitor compares every cycle.
module tb_weight_skew_array;

    localparam int COLS  = 32;
    localparam int DEPTH = 32;
    localparam int NP    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_bcast = 1'b0;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic        replay = 1'b0;
    logic [31:0] wr_data = '0;
    logic [4:0]  wr_col = '0;
    logic [5:0]  weight_dim = '0;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] weight_out [COLS];
    logic [COLS-1:0] out_vld;

    weight_skew_array dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_col     (wr_col),
        .wr_bcast   (wr_bcast),
        .flush      (flush),
        .start      (start),
        .replay     (replay),
        .weight_dim (weight_dim),
        .weight_out (weight_out),
        .out_vld    (out_vld),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    exp_t        eq [COLS][$];
    logic [15:0] mq [COLS][$];
    bit          busy_at [int];
    bit          done_at [int];
    bit          err_at  [int];
    int          idle_from = 0;

    // Monitor: pops expected weights whenever a column presents one.
    always @(negedge clk) begin : mon
        exp_t e;
        bit   x;
        if (mon_en) begin
            for (int c = 0; c < COLS; c++) begin
                if (eq[c].size() > 0 && eq[c][0].cyc < cyc) begin
                    checks++; errors++;
                    $display("FAIL missing_out col=%0d: no out_vld, required at cycle %0d data %h",
                             c, eq[c][0].cyc, eq[c][0].d);
                    void'(eq[c].pop_front());
                end
                checks++;
                if (out_vld[c]) begin
                    if (eq[c].size() == 0) begin
                        errors++;
                        $display("FAIL spurious_out col=%0d cycle=%0d: actual %h, required no output",
                                 c, cyc, weight_out[c]);
                    end else begin
                        e = eq[c].pop_front();
                        if (e.cyc != cyc || weight_out[c] !== e.d) begin
                            errors++;
                            $display("FAIL stream col=%0d: actual cycle %0d data %h, required cycle %0d data %h",
                                     c, cyc, weight_out[c], e.cyc, e.d);
                        end
                    end
                end else if (weight_out[c] !== 16'h0) begin
                    errors++;
                    $display("FAIL gate col=%0d cycle=%0d: actual %h, required 0", c, cyc, weight_out[c]);
                end
            end
            x = busy_at.exists(cyc);
            checks++;
            if (busy !== x) begin
                errors++;
                $display("FAIL busy cycle=%0d: actual %b, required %b", cyc, busy, x);
            end
            x = done_at.exists(cyc);
            checks++;
            if (done !== x) begin
                errors++;
                $display("FAIL done cycle=%0d: actual %b, required %b", cyc, done, x);
            end
            x = err_at.exists(cyc);
            checks++;
            if (err !== x) begin
                errors++;
                $display("FAIL err cycle=%0d: actual %b, required %b", cyc, err, x);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_idle();
        return cyc >= idle_from;
    endfunction

    function automatic int min_cnt();
        int m;
        m = DEPTH + 1;
        for (int c = 0; c < COLS; c++) if (mq[c].size() < m) m = mq[c].size();
        return m;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < COLS; c++) mq[c].delete();
    endtask

    task automatic chk_ready(input logic expv, input string tag);
        checks++;
        if (wr_ready !== expv) begin
            errors++;
            $display("FAIL ready_%s cycle=%0d: actual %b, required %b", tag, cyc, wr_ready, expv);
        end
    endtask

    task automatic do_write(input logic [31:0] d, input int col, input bit bc, input bit fl);
        bit rdy;
        wr_valid = 1'b1; wr_data = d; wr_col = 5'(col); wr_bcast = bc; flush = fl;
        #1;
        rdy = model_idle();
        if (rdy) begin
            if (bc) begin
                for (int c = 0; c < COLS; c++) if (DEPTH - mq[c].size() < NP) rdy = 1'b0;
            end else if (DEPTH - mq[col].size() < NP) begin
                rdy = 1'b0;
            end
        end
        chk_ready(rdy, "write");
        if (fl && model_idle()) begin
            clear_model();
        end else if (rdy) begin
            for (int c = 0; c < COLS; c++) begin
                if (bc || c == col) begin
                    mq[c].push_back(d[15:0]);
                    mq[c].push_back(d[31:16]);
                end
            end
        end
        tick();
        wr_valid = 1'b0; wr_bcast = 1'b0; flush = 1'b0;
    endtask

    task automatic do_start(input int wd, input bit rep);
        int   k;
        exp_t e;
        k = cyc;
        start = 1'b1; weight_dim = 6'(wd); replay = rep;
        #1;
        chk_ready(1'b0, "start");
        if (model_idle()) begin
            if (wd >= 1 && wd <= min_cnt()) begin
                for (int c = 0; c < COLS; c++) begin
                    for (int i = 0; i < wd; i++) begin
                        e.cyc = k + 1 + c + i;
                        e.d   = mq[c][i];
                        eq[c].push_back(e);
                    end
                end
                for (int j = k + 1; j <= k + wd + COLS - 1; j++) busy_at[j] = 1'b1;
                done_at[k + wd + COLS] = 1'b1;
                idle_from = k + wd + COLS;
                if (!rep) for (int c = 0; c < COLS; c++) repeat (wd) void'(mq[c].pop_front());
            end else begin
                err_at[k + 1] = 1'b1;
            end
        end
        tick();
        start = 1'b0; replay = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        #1;
        if (model_idle()) clear_model();
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!model_idle() && n < 500) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic reset_mid();
        int r;
        r = cyc;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            while (eq[c].size() > 0 && eq[c][$].cyc > r) void'(eq[c].pop_back());
        end
        for (int j = r + 1; j < r + 120; j++) begin
            busy_at.delete(j);
            done_at.delete(j);
        end
        clear_model();
        idle_from = r + 1;
    endtask

    initial begin
        int r;
        int m;
        int wd;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Column 3 gets 1,2,3,4; other columns random so the start is legal.
        for (int c = 0; c < COLS; c++) begin
            if (c == 3) begin
                do_write(32'h0002_0001, 3, 1'b0, 1'b0);
                do_write(32'h0004_0003, 3, 1'b0, 1'b0);
            end else begin
                do_write($urandom, c, 1'b0, 1'b0);
                do_write($urandom, c, 1'b0, 1'b0);
            end
        end
        do_start(5, 1'b0);
        do_start(0, 1'b0);
        do_start(4, 1'b0);
        wait_idle();
        do_start(1, 1'b0);
        tick();

        // Replay then consume: identical streams, then empty.
        for (int c = 0; c < COLS; c++) begin
            do_write($urandom, c, 1'b0, 1'b0);
            do_write($urandom, c, 1'b0, 1'b0);
        end
        do_start(4, 1'b1);
        tick();
        do_start(2, 1'b0);
        wait_idle();
        do_start(4, 1'b0);
        wait_idle();
        do_start(1, 1'b0);
        tick();

        // Broadcast fill, stall, full skewed drain, flush behaviour.
        repeat (DEPTH / NP) do_write($urandom, 0, 1'b1, 1'b0);
        repeat (3) do_write($urandom, 5, 1'b0, 1'b0);
        do_write($urandom, 5, 1'b1, 1'b0);
        do_start(32, 1'b1);
        wait_idle();
        do_write($urandom, 5, 1'b0, 1'b1);
        do_write($urandom, 5, 1'b0, 1'b0);
        do_write($urandom, 7, 1'b0, 1'b1);
        do_start(1, 1'b0);
        tick();

        // DEPTH-1 entries and pointer wrap across rounds.
        repeat (DEPTH / NP) do_write($urandom, 0, 1'b1, 1'b0);
        do_start(1, 1'b0);
        wait_idle();
        do_write($urandom, 9, 1'b0, 1'b0);
        do_start(31, 1'b0);
        wait_idle();
        repeat (10) do_write($urandom, 0, 1'b1, 1'b0);
        do_start(20, 1'b0);
        wait_idle();
        for (int c = 0; c < COLS; c++) repeat (3) do_write($urandom, c, 1'b0, 1'b0);
        do_start(6, 1'b0);
        wait_idle();

        // Randomized traffic.
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                do_write($urandom, $urandom_range(0, COLS - 1), 1'($urandom_range(0, 1)), 1'b0);
            end else if (r == 6) begin
                if ($urandom_range(0, 1) == 0) do_flush();
                else do_write($urandom, $urandom_range(0, COLS - 1), 1'b0, 1'b1);
            end else begin
                m  = min_cnt();
                wd = $urandom_range(0, (m + 1 > 33) ? 33 : m + 1);
                do_start(wd, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) do_start($urandom_range(1, 4), 1'b0);
                wait_idle();
            end
        end

        // Reset in the middle of a drain at t=2.
        do_flush();
        repeat (4) do_write($urandom, 0, 1'b1, 1'b0);
        do_start(8, 1'b0);
        tick();
        tick();
        reset_mid();
        do_start(1, 1'b0);
        repeat (40) tick();

        for (int c = 0; c < COLS; c++) begin
            checks++;
            if (eq[c].size() != 0) begin
                errors++;
                $display("FAIL leftover col=%0d: actual %0d pending, required 0", c, eq[c].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
